uart_tx_arbiter: RTL and testbench

Shares the single `uart_tx` transmitter among `NREQ` byte sources (e.g. several TX FIFOs) using round-robin arbitration with a bounded burst lock. The block sits between the requesters' FIFO read ports and the `uart_tx` `data_in`/`valid`/`tx_ready` handshake. It pops one byte from the granted requester and holds it stable until the transmitter accepts it. It also keeps a running count of transmitted bytes.

---
 rtl/uart_tx_arbiter.sv | 103 ++++++++++
 tb/tb_uart_tx_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among NREQ byte sources, with a bounded
// burst lock on the current winner and a running count of accepted bytes.
//
// state  | meaning
// ARB    | pick a winner, pop its byte and capture it into tx_data
// OFFER  | tx_valid high, hold tx_data until tx_ready accepts it
// SETTLE | one dead cycle while uart_tx drops tx_ready
module uart_tx_arbiter #(
   parameter int NREQ      = 4,
   parameter int MAX_BURST = 4,
   parameter int IDW       = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [8*NREQ-1:0]    req_data,
   output logic [NREQ-1:0]      req_ready,
   output logic [7:0]           tx_data,
   output logic                 tx_valid,
   input  logic                 tx_ready,
   output logic [IDW-1:0]       grant_id,
   output logic                 busy,
   output logic [15:0]          byte_count
);

   typedef enum logic [1:0] {ARB, OFFER, SETTLE} state_t;

   state_t         state;
   logic           lock;
   logic [7:0]     burst_cnt;
   logic [IDW-1:0] winner;
   logic [IDW-1:0] cand;
   logic           found;
   logic           lock_hit;
   logic           any_req;

   assign any_req = |req_valid;
   assign busy    = (state != ARB);

   // The lock keeps the current winner; otherwise search upward from grant_id+1,
   // wrapping, so the last winner is considered last.
   always_comb begin
      winner   = grant_id;
      cand     = grant_id;
      found    = 1'b0;
      lock_hit = lock && req_valid[grant_id] && (burst_cnt < 8'(MAX_BURST));
      if (!lock_hit) begin
         for (int k = 1; k <= NREQ; k++) begin
            cand = IDW'((int'(grant_id) + k) % NREQ);
            if (!found && req_valid[cand]) begin
               winner = cand;
               found  = 1'b1;
            end
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (rst_n && state == ARB && any_req)
         req_ready[winner] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= ARB;
         tx_valid   <= 1'b0;
         tx_data    <= 8'h00;
         grant_id   <= IDW'(NREQ - 1);
         lock       <= 1'b0;
         burst_cnt  <= 8'd0;
         byte_count <= 16'd0;
      end else begin
         case (state)
            ARB: begin
               if (any_req) begin
                  tx_data  <= req_data[{winner, 3'b000} +: 8];
                  tx_valid <= 1'b1;
                  if (winner == grant_id && lock)
                     burst_cnt <= burst_cnt + 8'd1;
                  else
                     burst_cnt <= 8'd1;
                  grant_id <= winner;
                  lock     <= 1'b1;
                  state    <= OFFER;
               end else begin
                  lock <= 1'b0;
               end
            end
            OFFER: begin
               if (tx_ready) begin
                  byte_count <= byte_count + 16'd1;
                  tx_valid   <= 1'b0;
                  state      <= SETTLE;
               end
            end
            SETTLE: state <= ARB;
            default: state <= ARB;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: cycle table for the basic handshake, scoreboarded
// grant sequences for round-robin and burst locking, and reset mid-offer.
module tb_uart_tx_arbiter;
   localparam int NREQ = 4;
   localparam int IDW  = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst_n;
   logic [NREQ-1:0]   req_valid;
   logic [8*NREQ-1:0] req_data;
   logic              tx_ready;

   logic [NREQ-1:0] req_ready,  rr_req_ready;
   logic [7:0]      tx_data,    rr_tx_data;
   logic            tx_valid,   rr_tx_valid;
   logic [IDW-1:0]  grant_id,   rr_grant_id;
   logic            busy,       rr_busy;
   logic [15:0]     byte_count, rr_byte_count;

   uart_tx_arbiter #(.NREQ(NREQ), .MAX_BURST(4), .IDW(IDW)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .grant_id(grant_id), .busy(busy), .byte_count(byte_count)
   );

   uart_tx_arbiter #(.NREQ(NREQ), .MAX_BURST(1), .IDW(IDW)) dut_rr (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
      .req_ready(rr_req_ready), .tx_data(rr_tx_data), .tx_valid(rr_tx_valid),
      .tx_ready(tx_ready), .grant_id(rr_grant_id), .busy(rr_busy), .byte_count(rr_byte_count)
   );

   typedef struct {
      logic [3:0]  rv;
      logic        tr;
      logic [3:0]  e_rr;
      logic        e_tv;
      logic [7:0]  e_td;
      logic [15:0] e_bc;
      logic        e_busy;
      logic [1:0]  e_gid;
   } vec_t;

   typedef struct {
      logic [1:0] gid;
      logic [7:0] data;
   } exp_t;

   vec_t tbl[9];
   exp_t exp_q[$];

   int checks = 0;
   int errors = 0;
   int acc_cnt = 0;
   int cyc = 0;
   int last_acc = -1;
   logic mon_en = 1'b0;
   logic mon_rr = 1'b0;
   logic chk_spacing = 1'b0;
   logic prev_tv = 1'b0, prev_rr_tv = 1'b0;
   logic [7:0] prev_td = 8'h00, prev_rr_td = 8'h00;

   always @(posedge clk) cyc <= cyc + 1;

   // Invariants on both instances, plus the acceptance scoreboard.
   always @(negedge clk) begin
      logic       acc;
      logic [1:0] a_gid;
      logic [7:0] a_td;
      exp_t       e;
      if (rst_n) begin
         checks++;
         if ((req_ready & ~req_valid) != 4'b0 || !$onehot0(req_ready) ||
             (rr_req_ready & ~req_valid) != 4'b0 || !$onehot0(rr_req_ready)) begin
            errors++;
            $display("FAIL req_ready_legal: got %b/%b with req_valid %b", req_ready, rr_req_ready, req_valid);
         end
         checks++;
         if ((prev_tv && tx_valid && tx_data != prev_td) ||
             (prev_rr_tv && rr_tx_valid && rr_tx_data != prev_rr_td)) begin
            errors++;
            $display("FAIL tx_data_stable: got %h/%h, held value %h/%h", tx_data, rr_tx_data, prev_td, prev_rr_td);
         end
         if (mon_en) begin
            acc   = mon_rr ? (rr_tx_valid && tx_ready) : (tx_valid && tx_ready);
            a_gid = mon_rr ? rr_grant_id : grant_id;
            a_td  = mon_rr ? rr_tx_data : tx_data;
            if (acc) begin
               acc_cnt++;
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL accept_unexpected: got grant %0d data %h, expected no acceptance", a_gid, a_td);
               end else begin
                  e = exp_q.pop_front();
                  if (a_gid != e.gid || a_td != e.data) begin
                     errors++;
                     $display("FAIL accept_seq: got grant %0d data %h, expected grant %0d data %h", a_gid, a_td, e.gid, e.data);
                  end
               end
               if (chk_spacing && last_acc >= 0) begin
                  checks++;
                  if (cyc - last_acc != 3) begin
                     errors++;
                     $display("FAIL accept_spacing: got %0d cycles, expected 3", cyc - last_acc);
                  end
               end
               last_acc = cyc;
            end
         end
      end
      prev_tv    = tx_valid;
      prev_td    = tx_data;
      prev_rr_tv = rr_tx_valid;
      prev_rr_td = rr_tx_data;
   end

   task automatic do_reset();
      rst_n     = 1'b0;
      req_valid = 4'b0000;
      tx_ready  = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic wait_acc(input int n, input int budget);
      int k;
      k = 0;
      while (acc_cnt < n && k < budget) begin
         @(posedge clk);
         #1;
         k++;
      end
      checks++;
      if (acc_cnt < n) begin
         errors++;
         $display("FAIL wait_acc: got %0d acceptances, expected %0d", acc_cnt, n);
      end
   endtask

   task automatic push_exp(input logic [1:0] g);
      exp_t e;
      e.gid  = g;
      e.data = {6'b101000, g};
      exp_q.push_back(e);
   endtask

   task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, got, want);
      end
   endtask

   initial begin
      tbl[0] = '{4'b0001, 1'b0, 4'b0001, 1'b0, 8'h00, 16'd0, 1'b0, 2'd3};
      for (int i = 1; i <= 5; i++)
         tbl[i] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 8'h55, 16'd0, 1'b1, 2'd0};
      tbl[6] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 8'h55, 16'd0, 1'b1, 2'd0};
      tbl[7] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 8'h55, 16'd1, 1'b1, 2'd0};
      tbl[8] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 8'h55, 16'd1, 1'b0, 2'd0};

      // Single byte from requester 0, held while tx_ready is low.
      req_data = {8'hA3, 8'hA2, 8'hA1, 8'h55};
      do_reset();
      for (int i = 0; i < 9; i++) begin
         req_valid = tbl[i].rv;
         tx_ready  = tbl[i].tr;
         @(negedge clk);
         checks++;
         if ({req_ready, tx_valid, tx_data, byte_count, busy, grant_id} !==
             {tbl[i].e_rr, tbl[i].e_tv, tbl[i].e_td, tbl[i].e_bc, tbl[i].e_busy, tbl[i].e_gid}) begin
            errors++;
            $display("FAIL vec%0d: got rr=%b tv=%b td=%h bc=%0d busy=%b gid=%0d, expected rr=%b tv=%b td=%h bc=%0d busy=%b gid=%0d",
                     i, req_ready, tx_valid, tx_data, byte_count, busy, grant_id,
                     tbl[i].e_rr, tbl[i].e_tv, tbl[i].e_td, tbl[i].e_bc, tbl[i].e_busy, tbl[i].e_gid);
         end
         @(posedge clk);
         #1;
      end

      // Pure round-robin, everyone valid, tx_ready tied high.
      req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
      do_reset();
      acc_cnt = 0; last_acc = -1; mon_rr = 1'b1; chk_spacing = 1'b1;
      for (int i = 0; i < 8; i++) push_exp(2'(i % 4));
      req_valid = 4'b1111; tx_ready = 1'b1; mon_en = 1'b1;
      wait_acc(8, 60);
      req_valid = 4'b0000; mon_en = 1'b0; chk_spacing = 1'b0;
      repeat (2) @(posedge clk);
      #1 check_val("rr_byte_count", 32'(rr_byte_count), 32'd8);
      check_val("rr_queue_left", exp_q.size(), 0);
      exp_q.delete();

      // Burst lock of 4 between requesters 1 and 2.
      do_reset();
      acc_cnt = 0; mon_rr = 1'b0;
      for (int i = 0; i < 12; i++) push_exp((i % 8) < 4 ? 2'd1 : 2'd2);
      req_valid = 4'b0110; tx_ready = 1'b1; mon_en = 1'b1;
      wait_acc(12, 80);
      req_valid = 4'b0000; mon_en = 1'b0;
      repeat (2) @(posedge clk);
      #1 check_val("burst_byte_count", 32'(byte_count), 32'd12);
      exp_q.delete();

      // Requester 0 drops mid-burst; requester 3 must start a fresh burst.
      do_reset();
      acc_cnt = 0;
      push_exp(2'd0); push_exp(2'd0);
      for (int i = 0; i < 4; i++) push_exp(2'd3);
      push_exp(2'd0);
      req_valid = 4'b1001; tx_ready = 1'b1; mon_en = 1'b1;
      wait_acc(2, 20);
      req_valid = 4'b1000;
      wait_acc(3, 20);
      req_valid = 4'b1001;
      wait_acc(7, 40);
      req_valid = 4'b0000; mon_en = 1'b0;
      repeat (2) @(posedge clk);
      #1 check_val("drop_byte_count", 32'(byte_count), 32'd7);
      exp_q.delete();

      // Reset while a captured byte waits in OFFER.
      tx_ready  = 1'b0;
      req_valid = 4'b0100;
      @(posedge clk);
      #1 req_valid = 4'b0000;
      @(negedge clk);
      check_val("offer_tx_valid", 32'(tx_valid), 32'd1);
      check_val("offer_grant", 32'(grant_id), 32'd2);
      check_val("offer_data", 32'(tx_data), 32'hA2);
      check_val("offer_byte_count", 32'(byte_count), 32'd7);
      @(posedge clk);
      #1 rst_n = 1'b0; req_valid = 4'b0100;
      @(negedge clk);
      check_val("rst_req_ready", 32'(req_ready), 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1; req_valid = 4'b0000;
      @(negedge clk);
      check_val("rst_tx_valid", 32'(tx_valid), 32'd0);
      check_val("rst_grant", 32'(grant_id), 32'd3);
      check_val("rst_byte_count", 32'(byte_count), 32'd0);
      check_val("rst_busy", 32'(busy), 32'd0);
      check_val("rst_tx_data", 32'(tx_data), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
